// File: rtl/uart_tx_serializer_if.sv
// Handshake and line-side signals of the UART transmit serializer.
// master = upstream word source, slave = the serializer itself.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx, busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer driven by the rising edges of an external baud square wave.
// Define UART_TX_PARITY_EN to insert an even parity bit between the last data bit and the stop bit(s).
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               baud_in,
    uart_tx_serializer_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 baud_q;
    logic                 tick;
    logic                 accept;
    logic                 done_c;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // A baud rising edge seen in the same cycle as an accept is dropped: ALIGN is entered afterwards.
    assign tick   = baud_in & ~baud_q;
    assign accept = bus.tx_valid & (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            baud_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            baud_q     <= baud_in;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state and line value; every transition past ALIGN advances only on a tick.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shift_d = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q < LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_done  = done_c & ~reset;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: an 8N1 instance and a 7-bit / 2-stop instance on a shared 16-clk baud wave.
// Expected frames are written out by hand; parity variants follow UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] baud_cnt = 4'd0;
    logic       baud_in;

    int n_cmp = 0;
    int n_err = 0;
    int done8 = 0;
    int done7 = 0;
    bit sel   = 1'b0;

    logic tx_s, busy_s, ready_s, done_s;

    uart_tx_serializer_if #(.DATA_BITS(8)) bus8 ();
    uart_tx_serializer_if #(.DATA_BITS(7)) bus7 ();

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .baud_in (baud_in),
        .bus     (bus8.slave)
    );

    uart_tx_serializer #(.DATA_BITS(7), .STOP_BITS(2)) dut7 (
        .clk     (clk),
        .reset   (reset),
        .baud_in (baud_in),
        .bus     (bus7.slave)
    );

    always #5 clk = ~clk;

    // 8 clk high / 8 clk low baud wave
    always @(posedge clk) baud_cnt <= baud_cnt + 4'd1;
    assign baud_in = baud_cnt[3];

    always @(posedge clk) begin
        if (bus8.tx_done) done8 <= done8 + 1;
        if (bus7.tx_done) done7 <= done7 + 1;
    end

    assign tx_s    = sel ? bus7.tx       : bus8.tx;
    assign busy_s  = sel ? bus7.busy     : bus8.busy;
    assign ready_s = sel ? bus7.tx_ready : bus8.tx_ready;
    assign done_s  = sel ? bus7.tx_done  : bus8.tx_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_word(input bit s, input logic [8:0] data, input logic valid);
        if (s) begin
            bus7.tx_data  = data[6:0];
            bus7.tx_valid = valid;
        end else begin
            bus8.tx_data  = data[7:0];
            bus8.tx_valid = valid;
        end
    endtask

    // Send one word and check every line bit mid-period plus tx_done timing relative to the start edge.
    task automatic run_frame(input bit s, input logic [8:0] data, input logic [15:0] exp_bits,
                             input int nbits, input string tag, input bit hold,
                             input logic [8:0] next_data);
        int t;
        int d0;
        sel = s;
        d0  = s ? done7 : done8;
        @(negedge clk);
        set_word(s, data, 1'b1);
        t = 0;
        while (!busy_s && t < 100) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_accept", tag), 32'(busy_s), 32'd1);
        if (!hold) set_word(s, data, 1'b0);
        t = 0;
        while (tx_s && t < 40) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_start_seen", tag), 32'(tx_s), 32'd0);
        check($sformatf("%s_align_le16", tag), 32'(t <= 16), 32'd1);
        repeat (7) @(negedge clk);
        t = 7;
        for (int i = 0; i < nbits; i++) begin
            check($sformatf("%s_bit%0d", tag, i), 32'(tx_s), 32'(exp_bits[i]));
            if (i < nbits - 1) begin
                repeat (16) @(negedge clk);
                t += 16;
            end
        end
        while (!done_s && t < 16 * nbits + 20) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_done_time", tag), 32'(t), 32'(16 * nbits - 1));
        if (hold) set_word(s, next_data, 1'b1);
        @(negedge clk);
        check($sformatf("%s_ready_after", tag), 32'(ready_s), 32'd1);
        check($sformatf("%s_done_count", tag), 32'((s ? done7 : done8) - d0), 32'd1);
    endtask

    logic [15:0] e_a5, e_01, e_55, e_aa, e_3c, e_7f;
    int          n8, n7;
    int          d_before;

    initial begin
`ifdef UART_TX_PARITY_EN
        e_a5 = 16'({1'b1, 1'b0, 8'hA5, 1'b0});
        e_01 = 16'({1'b1, 1'b1, 8'h01, 1'b0});
        e_55 = 16'({1'b1, 1'b0, 8'h55, 1'b0});
        e_aa = 16'({1'b1, 1'b0, 8'hAA, 1'b0});
        e_3c = 16'({1'b1, 1'b0, 8'h3C, 1'b0});
        e_7f = 16'({2'b11, 1'b1, 7'h7F, 1'b0});
        n8   = 11;
        n7   = 11;
`else
        e_a5 = 16'({1'b1, 8'hA5, 1'b0});
        e_01 = 16'({1'b1, 8'h01, 1'b0});
        e_55 = 16'({1'b1, 8'h55, 1'b0});
        e_aa = 16'({1'b1, 8'hAA, 1'b0});
        e_3c = 16'({1'b1, 8'h3C, 1'b0});
        e_7f = 16'({2'b11, 7'h7F, 1'b0});
        n8   = 10;
        n7   = 10;
`endif
        bus8.tx_data  = '0;
        bus8.tx_valid = 1'b0;
        bus7.tx_data  = '0;
        bus7.tx_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_state8", 32'({bus8.tx, bus8.tx_ready, bus8.busy, bus8.tx_done}), 32'b1100);
        check("reset_state7", 32'({bus7.tx, bus7.tx_ready, bus7.busy, bus7.tx_done}), 32'b1100);

        // Idle line with the baud wave running
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check($sformatf("idle_%0d", i), 32'({bus8.tx, bus8.tx_ready, bus8.busy, bus8.tx_done}), 32'b1100);
        end

        run_frame(1'b0, 9'h0A5, e_a5, n8, "a5", 1'b0, 9'h0);
        run_frame(1'b0, 9'h001, e_01, n8, "x01", 1'b0, 9'h0);

        // Back-to-back with tx_valid held high across the first tx_done
        run_frame(1'b0, 9'h055, e_55, n8, "b2b_first", 1'b1, 9'h0AA);
        @(negedge clk);
        check("b2b_accept_after_done", 32'(bus8.busy), 32'd1);
        run_frame(1'b0, 9'h0AA, e_aa, n8, "b2b_second", 1'b0, 9'h0);

        // Reset during data bit 3 of an all-zero word
        sel = 1'b0;
        d_before = done8;
        @(negedge clk);
        set_word(1'b0, 9'h000, 1'b1);
        for (int i = 0; i < 100 && !bus8.busy; i++) @(negedge clk);
        set_word(1'b0, 9'h000, 1'b0);
        for (int i = 0; i < 40 && bus8.tx; i++) @(negedge clk);
        repeat (71) @(negedge clk);
        check("rst_mid_bit3_low", 32'(bus8.tx), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(bus8.tx), 32'd1);
        check("rst_mid_idle", 32'({bus8.tx_ready, bus8.busy}), 32'b10);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 32'(done8 - d_before), 32'd0);
        check("rst_mid_line_high", 32'(bus8.tx), 32'd1);
        run_frame(1'b0, 9'h03C, e_3c, n8, "after_rst_3c", 1'b0, 9'h0);

        // 7 data bits, 2 stop bits
        run_frame(1'b1, 9'h07F, e_7f, n7, "d7s2_7f", 1'b0, 9'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer that sits directly downstream of the accumulator-based baud generator and consumes its baud_rate square-wave output.
- Each rising edge of the baud input is one bit period boundary.
- Accepts a parallel word over a valid/ready handshake and shifts out one frame on tx: start bit, data bits LSB first, optional even parity, then stop bit(s).
- Idle line is high.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- baud_in  input  1  baud square wave from the baud generator; rising edge = bit tick
- tx_data  input  DATA_BITS  word to transmit; sampled on handshake
- tx_valid  input  1  upstream has a word on tx_data
- tx_ready  output  1  block can accept a word; high only in IDLE
- tx  output  1  serial line, registered, idle high
- busy  output  1  frame in progress (any state other than IDLE)
- tx_done  output  1  single-cycle pulse when the last stop bit completes

Behaviour:
- Clock and reset: reset is reset, synchronous, active-high; clock is clk.
- Reset values:
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - state=IDLE, bit counter=0, shift register=0.
  - baud_q=0, so a high baud_in immediately after reset produces one tick.
- Tick detection:
  - baud_q <= baud_in every clock.
  - tick = baud_in & ~baud_q, one clk wide per baud rising edge.
  - tx updates on the clock edge following the cycle in which tick is high.
- Handshake:
  - Accept when tx_valid & tx_ready.
  - tx_data is latched into the shift register; state -> ALIGN.
  - tx_valid while not ready is ignored; no queueing.
- States:
  - IDLE: tx=1. On accept -> ALIGN.
  - ALIGN: tx=1, waits for the first tick so the start bit is a full bit period. On tick: tx<=0, -> START.
  - START: on tick: tx<=shift[0], shift right, bit counter=0, -> DATA.
  - DATA: on tick:
    - If bit counter < DATA_BITS-1: increment counter, tx<=next bit.
    - Otherwise: tx<=parity bit and -> PARITY when parity is enabled; else tx<=1 and -> STOP with stop counter=0.
  - PARITY: on tick: tx<=1, -> STOP, stop counter=0.
  - STOP: on tick:
    - If stop counter == STOP_BITS-1: -> IDLE and pulse tx_done for exactly that cycle.
    - Else increment the stop counter.
- tx_ready is asserted combinationally from state==IDLE. A new accept is possible at the earliest on the cycle after tx_done.
- Each line bit lasts exactly one baud period, measured tick to tick.
- Frame length is 1 + DATA_BITS + P + STOP_BITS ticks after ALIGN, where P=1 with parity enabled and 0 without.
- Reset mid-frame: the frame is abandoned; tx=1 and IDLE on the next clock; no tx_done pulse.
- No tick arriving (baud_in stuck): the block holds its state indefinitely; no timeout.
- A tick in the same cycle as an accept is not used; ALIGN waits for the next tick.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state is compiled in.
  - Parity bit = XOR of the latched data word, i.e. even parity, computed at accept time and held in a register.
  - Frame gains one bit.
- Undefined: no PARITY state and no parity register; DATA goes directly to STOP.

Test Plan:
- Reset then idle, baud_in period 16 clk (8 high / 8 low) -> tx=1, tx_ready=1, busy=0 and tx_done never pulses over 200 clocks.
- Send 0xA5, parity off -> after ALIGN, tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit held exactly 16 clk. tx_done pulses once at the end of the stop bit; tx_ready returns high.
- UART_TX_PARITY_EN defined: send 0xA5 then 0x01 -> parity bit 0 for 0xA5 and 1 for 0x01, inserted between data bit 7 and the stop bit.
- Back-to-back with tx_valid held high, 0x55 then 0xAA -> second accept occurs on the cycle after the first tx_done. Two complete frames result, separated only by the ALIGN wait (≤16 clk).
- Assert reset for 1 clk during data bit 3 -> tx=1 on the next clock, state IDLE, no tx_done. The next send of 0x3C transmits correctly.
- STOP_BITS=2, DATA_BITS=7: send 0x7F -> start bit, seven 1s, then line high for 2 bit periods before tx_done. Total 10 ticks after ALIGN.
